reg_port_arbiter: RTL and testbench

Shares the deskew register bank's single access port between two requesters. The host side is the AXI-lite bridge, which issues non-stallable write/read strobes. The engine side is the internal deskew calibration engine, which uses a req/gnt handshake. Host strobes are captured in one-entry pending slots and served ahead of the engine, and a starvation counter guarantees the engine progress. Read data is routed back to whichever requester issued the read.

---
 rtl/reg_port_arbiter_pkg.sv | 28 ++
 rtl/reg_port_arbiter_if.sv | 77 +++++++
 rtl/reg_port_pending_slot.sv | 38 +++
 rtl/reg_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the deskew register bank access port:
// requester ownership, issue selection codes and default geometry.
package deskew_reg_pkg;

   localparam int DEF_ADDR_WIDTH   = 32;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_STARVE_LIMIT = 8;

   // Who a bank read belongs to, carried alongside the access until data returns.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_HOST = 2'd1,
      OWN_ENG  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      SEL_NONE    = 2'd0,
      SEL_HOST_WR = 2'd1,
      SEL_HOST_RD = 2'd2,
      SEL_ENG     = 2'd3
   } sel_e;

   // Width of a counter that must hold values 0..limit inclusive.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Bundle of host strobes, engine handshake and bank port around the arbiter.
// slave is the arbiter's view, master is the surrounding logic's view.
interface reg_port_arbiter_if #(
   parameter int ADDR_WIDTH = deskew_reg_pkg::DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = deskew_reg_pkg::DEF_DATA_WIDTH
);

   // Host (AXI-lite bridge) side
   logic                  write_reg;
   logic                  read_reg;
   logic [ADDR_WIDTH-1:0] reg_waddr;
   logic [DATA_WIDTH-1:0] reg_wdata;
   logic [ADDR_WIDTH-1:0] reg_raddr;
   logic [DATA_WIDTH-1:0] reg_rdata;
   logic                  host_ovf;

   // Calibration engine side
   logic                  eng_req;
   logic                  eng_we;
   logic [ADDR_WIDTH-1:0] eng_addr;
   logic [DATA_WIDTH-1:0] eng_wdata;
   logic                  eng_gnt;
   logic [DATA_WIDTH-1:0] eng_rdata;
   logic                  eng_rvalid;

   // Register bank port
   logic                  bank_en;
   logic                  bank_we;
   logic [ADDR_WIDTH-1:0] bank_addr;
   logic [DATA_WIDTH-1:0] bank_wdata;
   logic [DATA_WIDTH-1:0] bank_rdata;

   modport slave (
      input  write_reg,
      input  read_reg,
      input  reg_waddr,
      input  reg_wdata,
      input  reg_raddr,
      output reg_rdata,
      output host_ovf,
      input  eng_req,
      input  eng_we,
      input  eng_addr,
      input  eng_wdata,
      output eng_gnt,
      output eng_rdata,
      output eng_rvalid,
      output bank_en,
      output bank_we,
      output bank_addr,
      output bank_wdata,
      input  bank_rdata
   );

   modport master (
      output write_reg,
      output read_reg,
      output reg_waddr,
      output reg_wdata,
      output reg_raddr,
      input  reg_rdata,
      input  host_ovf,
      output eng_req,
      output eng_we,
      output eng_addr,
      output eng_wdata,
      input  eng_gnt,
      input  eng_rdata,
      input  eng_rvalid,
      input  bank_en,
      input  bank_we,
      input  bank_addr,
      input  bank_wdata,
      output bank_rdata
   );

endinterface

// File: rtl/reg_port_pending_slot.sv
// One-entry capture register for a non-stallable host strobe, offering the
// access as a candidate in the strobe cycle and holding it until issued.
module reg_port_pending_slot #(
   parameter int WIDTH = 64
) (
   input  logic             axis_clk,
   input  logic             axis_rst_n,
   input  logic             strobe,
   input  logic [WIDTH-1:0] load_val,
   input  logic             issue,
   output logic             cand_valid,
   output logic [WIDTH-1:0] cand_val,
   output logic             overwrite
);

   logic             valid_q;
   logic [WIDTH-1:0] val_q;

   // A fresh strobe always wins: it replaces an unserved entry (latest wins)
   // and is the candidate offered this very cycle.
   assign cand_valid = valid_q | strobe;
   assign cand_val   = strobe ? load_val : val_q;
   assign overwrite  = strobe & valid_q;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         valid_q <= 1'b0;
         // NOTE: the payload is reset along with the valid bit so nothing downstream ever sees X.
         val_q   <= '0;
      end else if (issue) begin
         valid_q <= 1'b0;
      end else if (strobe) begin
         valid_q <= 1'b1;
         val_q   <= load_val;
      end
   end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares the deskew register bank port between host strobes and the
// calibration engine, with starvation protection and tagged read return.
module reg_port_arbiter
   import deskew_reg_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input logic               axis_clk,
   input logic               axis_rst_n,
   reg_port_arbiter_if.slave bus
);

   localparam int CNT_W = cnt_width(STARVE_LIMIT);
   localparam int WR_W  = ADDR_WIDTH + DATA_WIDTH;

   // Host pending slots
   logic                  wr_cand;
   logic [WR_W-1:0]       wr_val;
   logic                  wr_ovf;
   logic                  wr_issue;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  rd_cand;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ovf;
   logic                  rd_issue;

   // Selection and state
   sel_e                  sel;
   logic                  eng_req_eff;
   logic [CNT_W-1:0]      starve_cnt;
   owner_e                ret_tag_q;
   owner_e                ret_tag_d;

   // Output registers
   logic                  bank_en_q;
   logic                  bank_we_q;
   logic [ADDR_WIDTH-1:0] bank_addr_q;
   logic [DATA_WIDTH-1:0] bank_wdata_q;
   logic                  eng_gnt_q;
   logic [DATA_WIDTH-1:0] eng_rdata_q;
   logic                  eng_rvalid_q;
   logic [DATA_WIDTH-1:0] reg_rdata_q;
   logic                  host_ovf_q;

   reg_port_pending_slot #(
      .WIDTH (WR_W)
   ) u_wr_slot (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .strobe     (bus.write_reg),
      .load_val   ({bus.reg_waddr, bus.reg_wdata}),
      .issue      (wr_issue),
      .cand_valid (wr_cand),
      .cand_val   (wr_val),
      .overwrite  (wr_ovf)
   );

   reg_port_pending_slot #(
      .WIDTH (ADDR_WIDTH)
   ) u_rd_slot (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .strobe     (bus.read_reg),
      .load_val   (bus.reg_raddr),
      .issue      (rd_issue),
      .cand_valid (rd_cand),
      .cand_val   (rd_addr),
      .overwrite  (rd_ovf)
   );

   assign wr_addr = wr_val[WR_W-1:DATA_WIDTH];
   assign wr_data = wr_val[DATA_WIDTH-1:0];

   // The engine keeps eng_req up during its grant cycle, so that cycle's request is stale.
   assign eng_req_eff = bus.eng_req & ~eng_gnt_q;

   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = SEL_NONE;
      if (eng_req_eff && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
         sel = SEL_ENG;
      end else if (wr_cand) begin
         sel = SEL_HOST_WR;
      end else if (rd_cand) begin
         sel = SEL_HOST_RD;
      end else if (eng_req_eff) begin
         sel = SEL_ENG;
      end
   end

   assign wr_issue = (sel == SEL_HOST_WR);
   assign rd_issue = (sel == SEL_HOST_RD);

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         bank_en_q    <= 1'b0;
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         eng_gnt_q    <= 1'b0;
         eng_rdata_q  <= '0;
         eng_rvalid_q <= 1'b0;
         reg_rdata_q  <= '0;
         host_ovf_q   <= 1'b0;
         starve_cnt   <= '0;
         ret_tag_q    <= OWN_NONE;
         ret_tag_d    <= OWN_NONE;
      end else begin
         // NOTE: non-blocking throughout; later assignments below override these idle defaults.
         bank_en_q    <= (sel != SEL_NONE);
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         eng_gnt_q    <= 1'b0;
         ret_tag_q    <= OWN_NONE;

         case (sel)
            SEL_HOST_WR: begin
               bank_we_q    <= 1'b1;
               bank_addr_q  <= wr_addr;
               bank_wdata_q <= wr_data;
            end
            SEL_HOST_RD: begin
               bank_addr_q <= rd_addr;
               ret_tag_q   <= OWN_HOST;
            end
            SEL_ENG: begin
               bank_we_q    <= bus.eng_we;
               bank_addr_q  <= bus.eng_addr;
               bank_wdata_q <= bus.eng_wdata;
               eng_gnt_q    <= 1'b1;
               ret_tag_q    <= bus.eng_we ? OWN_NONE : OWN_ENG;
            end
            default: ;
         endcase

         // Tag follows the access by one more cycle to line up with bank_rdata.
         ret_tag_d    <= ret_tag_q;
         eng_rvalid_q <= (ret_tag_d == OWN_ENG);
         if (ret_tag_d == OWN_ENG) begin
            eng_rdata_q <= bus.bank_rdata;
         end
         if (ret_tag_d == OWN_HOST) begin
            reg_rdata_q <= bus.bank_rdata;
         end

         host_ovf_q <= host_ovf_q | wr_ovf | rd_ovf;

         if (!eng_req_eff || (sel == SEL_ENG)) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   assign bus.bank_en    = bank_en_q;
   assign bus.bank_we    = bank_we_q;
   assign bus.bank_addr  = bank_addr_q;
   assign bus.bank_wdata = bank_wdata_q;
   assign bus.eng_gnt    = eng_gnt_q;
   assign bus.eng_rdata  = eng_rdata_q;
   assign bus.eng_rvalid = eng_rvalid_q;
   assign bus.reg_rdata  = reg_rdata_q;
   assign bus.host_ovf   = host_ovf_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Self-checking bench for reg_port_arbiter: host vector table, engine
// contention/starvation, overflow and reset-during-read sequences.
module tb_reg_port_arbiter;

   localparam int LIMIT = 8;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic        hold;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   logic axis_clk;
   logic axis_rst_n;

   int   checks;
   int   errors;
   int   eng_wait;
   logic [31:0] exp_host_rdata;

   op_t  host_q[$];
   op_t  eng_q[$];
   vec_t vecs[8];

   reg_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   reg_port_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .bus        (bus)
   );

   initial begin
      axis_clk = 1'b0;
      forever #5 axis_clk = ~axis_clk;
   end

   // Register bank model: one-cycle read latency, preloaded during reset.
   logic [31:0] mem [64];
   always @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
         mem[2]         <= 32'h1234_5678;
         mem[4]         <= 32'h0BAD_F00D;
         bus.bank_rdata <= '0;
      end else if (bus.bank_en) begin
         if (bus.bank_we) mem[bus.bank_addr[7:2]] <= bus.bank_wdata;
         else             bus.bank_rdata <= mem[bus.bank_addr[7:2]];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, 64'(|{bus.reg_rdata, bus.host_ovf, bus.eng_gnt, bus.eng_rdata, bus.eng_rvalid,
                        bus.bank_en, bus.bank_we, bus.bank_addr, bus.bank_wdata}), 64'(0));
   endtask

   function automatic vec_t mk(input logic wr, input logic rd, input logic hold,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata);
      return vec_t'{wr: wr, rd: rd, hold: hold, addr: addr, wdata: wdata, exp_rdata: exp_rdata};
   endfunction

   // Scoreboard: every bank access is matched in order against its requester's queue.
   task automatic monitor();
      op_t op;
      forever begin
         @(negedge axis_clk);
         if (axis_rst_n) begin
            if (bus.eng_gnt) check("gnt_with_bank_en", 64'(bus.bank_en), 64'(1));
            if (bus.bank_en && bus.eng_gnt) begin
               check("eng_sb_nonempty", 64'(eng_q.size() != 0), 64'(1));
               if (eng_q.size() != 0) begin
                  op = eng_q.pop_front();
                  check("eng_sb_we", 64'(bus.bank_we), 64'(op.we));
                  check("eng_sb_addr", 64'(bus.bank_addr), 64'(op.addr));
                  if (op.we) check("eng_sb_wdata", 64'(bus.bank_wdata), 64'(op.data));
               end
            end else if (bus.bank_en) begin
               check("host_sb_nonempty", 64'(host_q.size() != 0), 64'(1));
               if (host_q.size() != 0) begin
                  op = host_q.pop_front();
                  check("host_sb_we", 64'(bus.bank_we), 64'(op.we));
                  check("host_sb_addr", 64'(bus.bank_addr), 64'(op.addr));
                  if (op.we) check("host_sb_wdata", 64'(bus.bank_wdata), 64'(op.data));
               end
            end else begin
               check("bank_we_idle", 64'(bus.bank_we), 64'(0));
            end
         end
      end
   endtask

   // Called just after a rising edge; returns just after the edge following the grant.
   task automatic eng_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic check_ret,
                             output int waited);
      bus.eng_req   = 1'b1;
      bus.eng_we    = we;
      bus.eng_addr  = addr;
      bus.eng_wdata = wdata;
      eng_q.push_back(op_t'{we: we, addr: addr, data: we ? wdata : 32'h0});
      waited = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge axis_clk);
         if (bus.eng_gnt) begin
            waited = k;
            break;
         end
      end
      check("eng_gnt_seen", 64'(waited >= 0), 64'(1));
      @(posedge axis_clk) #1;
      bus.eng_req = 1'b0;
      bus.eng_we  = 1'b0;
      if (check_ret && !we && waited >= 0) begin
         @(negedge axis_clk);
         check("eng_rvalid_early", 64'(bus.eng_rvalid), 64'(0));
         @(negedge axis_clk);
         check("eng_rvalid_g2", 64'(bus.eng_rvalid), 64'(1));
         check("eng_rdata_g2", 64'(bus.eng_rdata), 64'(exp_rdata));
      end
   endtask

   task automatic host_burst(input int period, input int n, input int drop, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         if (i % period == 0) begin
            bus.write_reg = 1'b1;
            bus.reg_waddr = base + 32'(4 * i);
            bus.reg_wdata = $urandom;
            if (i != drop) host_q.push_back(op_t'{we: 1'b1, addr: bus.reg_waddr, data: bus.reg_wdata});
         end else begin
            bus.write_reg = 1'b0;
         end
         @(posedge axis_clk) #1;
      end
      bus.write_reg = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(posedge axis_clk) #1;
      bus.write_reg = v.wr;
      bus.read_reg  = v.rd;
      bus.reg_waddr = v.addr;
      bus.reg_wdata = v.wdata;
      bus.reg_raddr = v.addr;
      if (v.wr) host_q.push_back(op_t'{we: 1'b1, addr: v.addr, data: v.wdata});
      if (v.rd) host_q.push_back(op_t'{we: 1'b0, addr: v.addr, data: 32'h0});
      @(posedge axis_clk) #1;
      bus.write_reg = 1'b0;
      bus.read_reg  = 1'b0;
      @(negedge axis_clk);
      check($sformatf("vec%0d_bank_en", idx), 64'(bus.bank_en), 64'(1));
      check($sformatf("vec%0d_bank_we", idx), 64'(bus.bank_we), 64'(v.wr));
      check($sformatf("vec%0d_bank_addr", idx), 64'(bus.bank_addr), 64'(v.addr));
      if (v.wr && v.rd) begin
         @(negedge axis_clk);
         check($sformatf("vec%0d_rd_after_wr_en", idx), 64'(bus.bank_en), 64'(1));
         check($sformatf("vec%0d_rd_after_wr_we", idx), 64'(bus.bank_we), 64'(0));
      end
      @(negedge axis_clk);
      check($sformatf("vec%0d_idle", idx), 64'(bus.bank_en), 64'(0));
      check($sformatf("vec%0d_rdata_not_early", idx), 64'(bus.reg_rdata), 64'(exp_host_rdata));
      if (v.rd) begin
         @(negedge axis_clk);
         check($sformatf("vec%0d_reg_rdata", idx), 64'(bus.reg_rdata), 64'(v.exp_rdata));
         exp_host_rdata = v.exp_rdata;
      end
      if (v.hold) begin
         repeat (10) @(negedge axis_clk);
         check($sformatf("vec%0d_rdata_hold", idx), 64'(bus.reg_rdata), 64'(v.exp_rdata));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks         = 0;
      errors         = 0;
      exp_host_rdata = '0;
      axis_rst_n     = 1'b0;
      bus.write_reg  = 1'b0;
      bus.read_reg   = 1'b0;
      bus.reg_waddr  = '0;
      bus.reg_wdata  = '0;
      bus.reg_raddr  = '0;
      bus.eng_req    = 1'b0;
      bus.eng_we     = 1'b0;
      bus.eng_addr   = '0;
      bus.eng_wdata  = '0;

      vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h04, 32'hDEAD_BEEF, 32'h0);
      vecs[1] = mk(1'b0, 1'b1, 1'b1, 32'h08, 32'h0,         32'h1234_5678);
      vecs[2] = mk(1'b1, 1'b1, 1'b0, 32'h0C, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      vecs[3] = mk(1'b0, 1'b1, 1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF);
      vecs[4] = mk(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,         32'h55AA_55AA);
      vecs[5] = mk(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0,         32'h0);
      vecs[6] = mk(1'b1, 1'b0, 1'b0, 32'hFC, 32'hFFFF_FFFF, 32'h0);
      vecs[7] = mk(1'b0, 1'b1, 1'b0, 32'hFC, 32'h0,         32'hFFFF_FFFF);

      fork
         monitor();
      join_none

      repeat (2) @(negedge axis_clk);
      check_zero("reset_outputs");
      @(posedge axis_clk) #1;
      axis_rst_n = 1'b1;

      // Uncontended engine write, read back by the host table below.
      @(posedge axis_clk) #1;
      eng_access(1'b1, 32'h20, 32'h55AA_55AA, 32'h0, 1'b0, eng_wait);
      check("eng_wr_wait", 64'(eng_wait), 64'(1));

      for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);
      check("ovf_after_table", 64'(bus.host_ovf), 64'(0));

      // Engine read against host writes every other cycle.
      @(posedge axis_clk) #1;
      fork
         host_burst(2, 30, -1, 32'h40);
         eng_access(1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b1, eng_wait);
      join
      check("contend_wait_le_limit", 64'(eng_wait <= LIMIT + 1), 64'(1));
      repeat (3) @(negedge axis_clk);
      check("ovf_after_contend", 64'(bus.host_ovf), 64'(0));

      // Back-to-back host writes: engine forced in at the limit, strobe 8 overwritten by 9.
      @(posedge axis_clk) #1;
      fork
         host_burst(1, 12, 8, 32'h80);
         eng_access(1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b1, eng_wait);
      join
      check("starve_wait_exact", 64'(eng_wait), 64'(LIMIT + 1));
      repeat (3) @(negedge axis_clk);
      check("ovf_set", 64'(bus.host_ovf), 64'(1));
      repeat (10) @(negedge axis_clk);
      check("ovf_sticky", 64'(bus.host_ovf), 64'(1));

      @(posedge axis_clk) #1;
      axis_rst_n = 1'b0;
      @(negedge axis_clk);
      check_zero("ovf_reset_outputs");
      check("ovf_cleared", 64'(bus.host_ovf), 64'(0));
      @(posedge axis_clk) #1;
      axis_rst_n = 1'b1;

      // Engine read granted at g, reset asserted during g+1: the return must vanish.
      @(posedge axis_clk) #1;
      eng_access(1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, eng_wait);
      check("midrd_wait", 64'(eng_wait), 64'(1));
      axis_rst_n = 1'b0;
      repeat (3) begin
         @(negedge axis_clk);
         check_zero("midrd_reset_outputs");
      end
      @(posedge axis_clk) #1;
      axis_rst_n = 1'b1;
      repeat (6) begin
         @(negedge axis_clk);
         check("midrd_no_rvalid", 64'(bus.eng_rvalid), 64'(0));
      end

      repeat (3) @(negedge axis_clk);
      check("host_sb_drained", 64'(host_q.size()), 64'(0));
      check("eng_sb_drained", 64'(eng_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
